// File: rtl/bitstream_decoder_pkg.sv
// Shared types and helpers for the stochastic bitstream decoder.
// The package is named bitstream_pkg. It holds the FSM state encoding and
// the window-size helper used by the decoder and its ones counter.
package bitstream_pkg;

  // Decoder FSM states: waiting for start, counting a window, result held
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } decoder_state_t;

  // Default log2 window size; must match the LFSR-compare generator
  localparam int unsigned DEFAULT_LENGTH = 32'd8;

  // Number of samples in one counting window
  function automatic int unsigned win_size(input int unsigned length);
    return 32'd1 << length;
  endfunction

endpackage

// File: rtl/bitstream_decoder_ones_counter.sv
// Window counter for the bitstream decoder (module bitstream_ones_counter).
// It counts valid samples and the ones among them. window_done flags the
// valid sample that completes a window of win_size(LENGTH) samples, so the
// caller can capture ones + sample_bit in that same cycle.
// Both counters are LENGTH+1 bits wide and top out at WIN, so they cannot wrap.
module bitstream_ones_counter
  import bitstream_pkg::*;
#(
  parameter int unsigned LENGTH = DEFAULT_LENGTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic              sample_bit,
  output logic [LENGTH:0]   ones,
  output logic [LENGTH:0]   samples,
  output logic              window_done
);

  localparam int unsigned    WIN         = win_size(LENGTH);
  localparam logic [LENGTH:0] LAST_SAMPLE = (LENGTH + 32'd1)'(WIN - 32'd1);
  localparam logic [LENGTH:0] ONE         = (LENGTH + 32'd1)'(32'd1);

  logic [LENGTH:0] bit_ext_s;

  // Zero-extend the incoming sample to counter width
  always_comb begin
    bit_ext_s = {{LENGTH{1'b0}}, sample_bit};
  end

  // Sample and ones counters: clear has priority over a counting enable
  always_ff @(posedge clk) begin
    if (rst) begin
      ones    <= {(LENGTH + 1){1'b0}};
      samples <= {(LENGTH + 1){1'b0}};
    end else if (clear) begin
      ones    <= {(LENGTH + 1){1'b0}};
      samples <= {(LENGTH + 1){1'b0}};
    end else if (enable) begin
      ones    <= ones + bit_ext_s;
      samples <= samples + ONE;
    end else begin
      ones    <= ones;
      samples <= samples;
    end
  end

  // A valid sample arriving while WIN-1 samples are already counted ends the window
  always_comb begin
    window_done = enable & (samples == LAST_SAMPLE);
  end

endmodule

// File: rtl/bitstream_decoder.sv
// Stochastic bitstream decoder: counts ones over 2**LENGTH valid samples and
// returns the count over a valid/ready handshake.
// Optional feature macro: BITSTREAM_DECODER_AUTORESTART_EN. When it is
// defined, accepting a result starts the next window at once, with the
// counters cleared. A sample offered in the acceptance cycle is not counted.
// When it is undefined, every window needs its own start pulse from IDLE.
module bitstream_decoder
  import bitstream_pkg::*;
#(
  parameter int unsigned LENGTH = DEFAULT_LENGTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              x,
  input  logic              x_valid,
  output logic              busy,
  output logic [LENGTH:0]   y,
  output logic              y_valid,
  input  logic              y_ready
);

  localparam int unsigned     WIN         = win_size(LENGTH);
  localparam logic [LENGTH:0] LAST_SAMPLE = (LENGTH + 32'd1)'(WIN - 32'd1);

  decoder_state_t  state_r;
  logic            clear_s;
  logic            count_en_s;
  logic            accept_s;
  logic            window_done_s;
  logic [LENGTH:0] ones_s;
  logic [LENGTH:0] samples_s;
  logic [LENGTH:0] x_ext_s;

  bitstream_ones_counter #(
    .LENGTH (LENGTH)
  ) u_ones_counter (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear_s),
    .enable      (count_en_s),
    .sample_bit  (x),
    .ones        (ones_s),
    .samples     (samples_s),
    .window_done (window_done_s)
  );

  // Counter control: clear on window entry, count only valid samples in ACCUM
  always_comb begin
    clear_s    = 1'b0;
    count_en_s = 1'b0;
    accept_s   = 1'b0;
    x_ext_s    = {{LENGTH{1'b0}}, x};
    case (state_r)
      IDLE: begin
        clear_s = start;
      end
      ACCUM: begin
        count_en_s = x_valid;
      end
      DONE: begin
        accept_s = y_valid & y_ready;
`ifdef BITSTREAM_DECODER_AUTORESTART_EN
        clear_s  = accept_s;
`endif
      end
      default: begin
        clear_s = 1'b1;
      end
    endcase
  end

  // Decoder FSM with registered busy, result and result-valid outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      y       <= {(LENGTH + 1){1'b0}};
      y_valid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= ACCUM;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        ACCUM: begin
          if (window_done_s) begin
            // The last sample is still on x, so it is added here
            y       <= ones_s + x_ext_s;
            y_valid <= 1'b1;
            busy    <= 1'b0;
            state_r <= DONE;
          end else if (samples_s > LAST_SAMPLE) begin
            // The counter can only reach this value if it is corrupted:
            // drop the window rather than run past WIN
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            busy    <= 1'b1;
            state_r <= ACCUM;
          end
        end
        DONE: begin
          if (accept_s) begin
            y_valid <= 1'b0;
`ifdef BITSTREAM_DECODER_AUTORESTART_EN
            busy    <= 1'b1;
            state_r <= ACCUM;
`else
            busy    <= 1'b0;
            state_r <= IDLE;
`endif
          end else begin
            y_valid <= 1'b1;
            busy    <= 1'b0;
            state_r <= DONE;
          end
        end
        default: begin
          y_valid <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitstream_decoder.sv
// Directed testbench for bitstream_decoder.
// dut4 runs with LENGTH=4 (WIN=16) for the directed window tests.
// dut8 runs with LENGTH=8 and is fed by an 8-bit LFSR-compare generator for x=128.
// Expectations follow BITSTREAM_DECODER_AUTORESTART_EN when it is defined.
module tb_bitstream_decoder;

`ifdef BITSTREAM_DECODER_AUTORESTART_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, x4, xv4, yr4, busy4, yv4;
  logic [4:0] y4;
  logic       start8, x8, xv8, yr8, busy8, yv8;
  logic [8:0] y8;
  logic [7:0] lfsr;

  int vec_count = 0;
  int err_count = 0;

  always #5 clk = ~clk;

  bitstream_decoder #(.LENGTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .x(x4), .x_valid(xv4),
    .busy(busy4), .y(y4), .y_valid(yv4), .y_ready(yr4)
  );

  bitstream_decoder #(.LENGTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .x(x8), .x_valid(xv8),
    .busy(busy8), .y(y8), .y_valid(yv8), .y_ready(yr8)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    start4 = 1'b0; x4 = 1'b0; xv4 = 1'b0; yr4 = 1'b0;
    start8 = 1'b0; x8 = 1'b0; xv8 = 1'b0; yr8 = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic start_window4;
    start4 = 1'b1;
    xv4 = 1'b0;
    step();
    start4 = 1'b0;
  endtask

  task automatic accept4;
    xv4 = 1'b0;
    yr4 = 1'b1;
    step();
    yr4 = 1'b0;
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic test_reset;
    do_reset();
    vec_count++;
    if (busy4 !== 1'b0 || yv4 !== 1'b0 || y4 !== 5'd0) begin
      err_count++;
      $display("FAIL reset4 got busy=%b yv=%b y=%0d want 0/0/0", busy4, yv4, y4);
    end
    vec_count++;
    if (busy8 !== 1'b0 || yv8 !== 1'b0 || y8 !== 9'd0) begin
      err_count++;
      $display("FAIL reset8 got busy=%b yv=%b y=%0d want 0/0/0", busy8, yv8, y8);
    end
  endtask

  // 1: sixteen ones give the full-scale count of 16
  task automatic test_all_ones;
    do_reset();
    start_window4();
    vec_count++;
    if (busy4 !== 1'b1) begin
      err_count++;
      $display("FAIL t1_busy got %b want 1", busy4);
    end
    x4 = 1'b1; xv4 = 1'b1;
    repeat (15) step();
    vec_count++;
    if (yv4 !== 1'b0) begin
      err_count++;
      $display("FAIL t1_early_valid got %b want 0", yv4);
    end
    step();
    vec_count++;
    if (yv4 !== 1'b1 || y4 !== 5'd16 || busy4 !== 1'b0) begin
      err_count++;
      $display("FAIL t1_result got yv=%b y=%0d busy=%b want 1/16/0", yv4, y4, busy4);
    end
    accept4();
    vec_count++;
    if (yv4 !== 1'b0 || busy4 !== AUTO || y4 !== 5'd16) begin
      err_count++;
      $display("FAIL t1_accept got yv=%b busy=%b y=%0d want 0/%0d/16", yv4, busy4, y4, AUTO);
    end
  endtask

  // 2: all zeros give 0; an alternating 1,0 pattern gives 8
  task automatic test_patterns;
    int exp_ones;
    do_reset();
    start_window4();
    x4 = 1'b0; xv4 = 1'b1;
    repeat (16) step();
    vec_count++;
    if (yv4 !== 1'b1 || y4 !== 5'd0) begin
      err_count++;
      $display("FAIL t2_zeros got yv=%b y=%0d want 1/0", yv4, y4);
    end
    accept4();
    start_window4();
    exp_ones = 0;
    for (int i = 0; i < 16; i++) begin
      x4 = (i % 2 == 0);
      xv4 = 1'b1;
      if (x4) exp_ones++;
      step();
    end
    vec_count++;
    if (yv4 !== 1'b1 || y4 !== 5'(exp_ones)) begin
      err_count++;
      $display("FAIL t2_alt got yv=%b y=%0d want 1/%0d", yv4, y4, exp_ones);
    end
    accept4();
  endtask

  // 3: stalled cycles are not counted
  task automatic test_stall;
    do_reset();
    start_window4();
    x4 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      xv4 = (i % 2 == 0);
      step();
      if (i == 29) begin
        vec_count++;
        if (yv4 !== 1'b0 || busy4 !== 1'b1) begin
          err_count++;
          $display("FAIL t3_midway got yv=%b busy=%b want 0/1", yv4, busy4);
        end
      end
    end
    vec_count++;
    if (yv4 !== 1'b1 || y4 !== 5'd16) begin
      err_count++;
      $display("FAIL t3_result got yv=%b y=%0d want 1/16", yv4, y4);
    end
    accept4();
  endtask

  // 4: back-pressure holds the result; start is dropped in DONE and on acceptance
  task automatic test_backpressure;
    do_reset();
    start_window4();
    for (int i = 0; i < 16; i++) begin
      x4 = (i < 5);
      xv4 = 1'b1;
      step();
    end
    yr4 = 1'b0; start4 = 1'b1; xv4 = 1'b1; x4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      vec_count++;
      if (yv4 !== 1'b1 || y4 !== 5'd5 || busy4 !== 1'b0) begin
        err_count++;
        $display("FAIL t4_hold%0d got yv=%b y=%0d busy=%b want 1/5/0", i, yv4, y4, busy4);
      end
    end
    yr4 = 1'b1;
    step();
    vec_count++;
    if (yv4 !== 1'b0 || y4 !== 5'd5) begin
      err_count++;
      $display("FAIL t4_accept got yv=%b y=%0d want 0/5", yv4, y4);
    end
    yr4 = 1'b0; start4 = 1'b0; xv4 = 1'b0;
    step();
    vec_count++;
    if (busy4 !== AUTO) begin
      err_count++;
      $display("FAIL t4_start_dropped got busy=%b want %0d", busy4, AUTO);
    end
    start_window4();
    x4 = 1'b0; xv4 = 1'b1;
    repeat (16) step();
    vec_count++;
    if (yv4 !== 1'b1 || y4 !== 5'd0) begin
      err_count++;
      $display("FAIL t4_next_window got yv=%b y=%0d want 1/0", yv4, y4);
    end
    accept4();
  endtask

  // 5: reset in mid-window discards the partial count
  task automatic test_reset_mid;
    do_reset();
    start_window4();
    x4 = 1'b1; xv4 = 1'b1;
    repeat (7) step();
    rst = 1'b1; xv4 = 1'b0;
    step();
    vec_count++;
    if (yv4 !== 1'b0 || busy4 !== 1'b0) begin
      err_count++;
      $display("FAIL t5_reset got yv=%b busy=%b want 0/0", yv4, busy4);
    end
    rst = 1'b0;
    start_window4();
    x4 = 1'b0; xv4 = 1'b1;
    repeat (16) step();
    vec_count++;
    if (yv4 !== 1'b1 || y4 !== 5'd0) begin
      err_count++;
      $display("FAIL t5_after got yv=%b y=%0d want 1/0", yv4, y4);
    end
    accept4();
  endtask

  // 6: three consecutive LENGTH=8 windows of an LFSR-compare stream at x=128
  task automatic test_generator;
    bit found;
    do_reset();
    lfsr = 8'h01;
    start8 = 1'b1; xv8 = 1'b0;
    step();
    start8 = 1'b0;
    for (int w = 0; w < 3; w++) begin
`ifndef BITSTREAM_DECODER_AUTORESTART_EN
      if (w > 0) begin
        start8 = 1'b1; xv8 = 1'b0;
        step();
        start8 = 1'b0;
      end
`endif
      found = 1'b0;
      for (int c = 0; c < 300 && !found; c++) begin
        x8 = (lfsr < 8'd128);
        xv8 = 1'b1;
        step();
        lfsr = lfsr_next(lfsr);
        if (yv8) found = 1'b1;
      end
      vec_count++;
      if (!found) begin
        err_count++;
        $display("FAIL t6_timeout window %0d got no y_valid want y_valid within 300 cycles", w);
      end
      vec_count++;
      if (y8 < 9'd126 || y8 > 9'd129) begin
        err_count++;
        $display("FAIL t6_range window %0d got %0d want 126..129", w, y8);
      end
      x8 = (lfsr < 8'd128);
      xv8 = 1'b1;
      yr8 = 1'b1;
      step();
      lfsr = lfsr_next(lfsr);
      yr8 = 1'b0;
      vec_count++;
      if (yv8 !== 1'b0 || busy8 !== AUTO) begin
        err_count++;
        $display("FAIL t6_accept window %0d got yv=%b busy=%b want 0/%0d", w, yv8, busy8, AUTO);
      end
    end
    xv8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_patterns();
    test_stall();
    test_backpressure();
    test_reset_mid();
    test_generator();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
